// File: rtl/rr_arb_mux_one_hot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux_one_hot_pkg
// Description : Shared arbitration-mode constants for the arbitrated mux.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_mux_one_hot_pkg;

  // Arbitration policy selectors for the RR_MODE parameter
  localparam int ARB_FIXED = 0;  // lowest asserted index always wins
  localparam int ARB_RR    = 1;  // rotating priority starting at the pointer

endpackage
`default_nettype wire

// File: rtl/rr_arb_mux_one_hot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_one_hot
// Description : One-hot request arbiter, round-robin or fixed priority.
//               Owns the rotation pointer; advances it past the winner
//               whenever the advance strobe reports an accepted grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_one_hot
  import rr_arb_mux_one_hot_pkg::*;
#(
  parameter int CH      = 4,
  parameter int RR_MODE = ARB_RR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] req_i,
  input  logic          adv_i,
  output logic [CH-1:0] grant_o
);

  localparam int              PW   = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [PW:0]     CH_W = (PW+1)'(CH);
  localparam logic [PW-1:0]   LAST = PW'(CH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW:0]   pos;
  logic [PW-1:0] win_idx;
  logic          found;

  // Search upward from the pointer (wrapping) for the first active request
  always_comb begin
    grant_o = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 0; i < CH; i++) begin
      pos = {1'b0, ptr_q} + (PW+1)'(i);
      if (pos >= CH_W) pos = pos - CH_W;
      if (!found && req_i[pos[PW-1:0]]) begin
        found                 = 1'b1;
        win_idx               = pos[PW-1:0];
        grant_o[pos[PW-1:0]]  = 1'b1;
      end
    end
  end

  // Next pointer: one past the accepted winner; fixed mode keeps it at 0
  always_comb begin
    ptr_d = ptr_q;
    if ((RR_MODE == ARB_RR) && adv_i) begin
      ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux_one_hot.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux_one_hot
// Description : N-channel arbitrated multiplexer. An internal arbiter picks
//               one requester (one-hot), an AND-OR mux selects its data and
//               a single valid/ready output register buffers the beat.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux_one_hot
  import rr_arb_mux_one_hot_pkg::*;
#(
  parameter int LENGTH  = 32,
  parameter int CH      = 4,
  parameter int RR_MODE = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*LENGTH-1:0] i_data,
  input  logic [CH-1:0]        i_valid,
  output logic [CH-1:0]        o_ready,
  output logic [LENGTH-1:0]    out,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CH-1:0]        o_grant
);

  logic [CH-1:0]     grant;
  logic              load_en;
  logic              xfer;
  logic [LENGTH-1:0] masked [CH];
  logic [LENGTH-1:0] sel_data;
  logic [LENGTH-1:0] out_q;
  logic [CH-1:0]     grant_q;
  logic              valid_q;

  rr_arbiter_one_hot #(
    .CH      (CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (i_valid),
    .adv_i   (xfer),
    .grant_o (grant)
  );

  // The register can take a beat when empty or being drained this cycle
  assign load_en = !valid_q || i_ready;
  assign o_ready = grant & {CH{load_en}};
  assign xfer    = |o_ready;

  // Gate each channel by its grant bit so the OR below is a one-hot select
  generate
    for (genvar k = 0; k < CH; k++) begin : g_sel
      assign masked[k] = i_data[k*LENGTH +: LENGTH] & {LENGTH{grant[k]}};
    end
  endgenerate

  // OR-reduce the masked channels into the selected data word
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CH; k++) begin
      sel_data = sel_data | masked[k];
    end
  end

  // Output stage: load on transfer, drop valid on an idle load, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else if (load_en) begin
      valid_q <= xfer;
      if (xfer) begin
        out_q   <= sel_data;
        grant_q <= grant;
      end
    end
  end

  assign out     = out_q;
  assign o_grant = grant_q;
  assign o_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux_one_hot.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_mux_one_hot
// Description : Self-checking bench. Drives a round-robin and a fixed-priority
//               instance with the same stimulus; a behavioural model checks
//               every cycle and directed literals pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux_one_hot;

  localparam int CH = 4;
  localparam int L  = 32;

  logic          clk;
  logic          rst;
  logic [31:0]   data_ch [CH];
  logic [CH*L-1:0] i_data;
  logic [CH-1:0] i_valid;
  logic          i_ready;

  logic [CH-1:0] rdy_rr, gr_rr, rdy_fx, gr_fx;
  logic [L-1:0]  out_rr, out_fx;
  logic          ov_rr, ov_fx;

  int checks   = 0;
  int failures = 0;

  assign i_data = {data_ch[3], data_ch[2], data_ch[1], data_ch[0]};

  rr_arb_mux_one_hot #(.LENGTH(L), .CH(CH), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(rdy_rr),
    .out(out_rr), .o_valid(ov_rr), .i_ready(i_ready), .o_grant(gr_rr)
  );

  rr_arb_mux_one_hot #(.LENGTH(L), .CH(CH), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(rdy_fx),
    .out(out_fx), .o_valid(ov_fx), .i_ready(i_ready), .o_grant(gr_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // index 0 = round-robin instance, 1 = fixed-priority instance
  logic [31:0] m_out   [2];
  logic        m_valid [2];
  logic [3:0]  m_grant [2];
  int          m_ptr   [2];
  bit          m_known = 1'b0;

  // Winner: first valid channel scanning upward from ptr with wraparound
  function automatic int pick(input logic [CH-1:0] v, input int ptr);
    for (int off = 0; off < CH; off++) begin
      if (v[(ptr + off) % CH]) return (ptr + off) % CH;
    end
    return -1;
  endfunction

  task automatic model_step(input int m, input string pfx, input logic [31:0] aout,
                            input logic aval, input logic [3:0] agr, input logic [3:0] ardy);
    int k;
    logic load;
    logic [3:0] exp_rdy;
    k       = pick(i_valid, (m == 0) ? m_ptr[m] : 0);
    load    = !m_valid[m] || i_ready;
    exp_rdy = (load && k >= 0) ? (4'b0001 << k) : 4'b0000;
    if (m_known) begin
      chk({pfx, "_out"},   aout,  m_out[m]);
      chk({pfx, "_valid"}, {31'd0, aval}, {31'd0, m_valid[m]});
      chk({pfx, "_grant"}, {28'd0, agr},  {28'd0, m_grant[m]});
      chk({pfx, "_ready"}, {28'd0, ardy}, {28'd0, exp_rdy});
    end
    if (rst) begin
      m_out[m] = '0; m_valid[m] = 1'b0; m_grant[m] = '0; m_ptr[m] = 0;
    end else if (load) begin
      m_valid[m] = (k >= 0);
      if (k >= 0) begin
        m_out[m]   = data_ch[k];
        m_grant[m] = 4'b0001 << k;
        m_ptr[m]   = (k + 1) % CH;
      end
    end
  endtask

  // Compare process: inputs are stable at the falling edge
  always @(negedge clk) begin
    model_step(0, "rr", out_rr, ov_rr, gr_rr, rdy_rr);
    model_step(1, "fx", out_fx, ov_fx, gr_fx, rdy_fx);
    if (rst) m_known = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  rot_gr  [5];
  logic [31:0] rot_out [5];
  logic [5:0]  pat     [16];

  initial begin
    rst     = 1'b1;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    for (int k = 0; k < CH; k++) data_ch[k] = 32'hA0 + k;
    rot_out = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    rot_gr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    // {i_ready, i_valid[3:0], spare}
    pat = '{6'b1_1010_0, 6'b0_1010_0, 6'b1_0101_0, 6'b1_1001_0,
            6'b0_1111_0, 6'b0_0001_0, 6'b1_0000_0, 6'b1_1000_0,
            6'b1_1000_0, 6'b1_0110_0, 6'b0_0110_0, 6'b1_0110_0,
            6'b1_1111_0, 6'b1_0011_0, 6'b1_1100_0, 6'b1_0001_0};

    // Reset with all channels requesting
    step(); step();
    chk("rst_out",   out_rr, 32'h0);
    chk("rst_valid", {31'd0, ov_rr}, 32'd0);
    chk("rst_grant", {28'd0, gr_rr}, 32'd0);
    chk("rst_fx_valid", {31'd0, ov_fx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_ready", {28'd0, rdy_rr}, 32'b0001);

    // Round-robin rotation
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rot_out",   out_rr, rot_out[i]);
      chk("rot_grant", {28'd0, gr_rr}, {28'd0, rot_gr[i]});
      chk("rot_valid", {31'd0, ov_rr}, 32'd1);
      chk("fx_rot_out", out_fx, 32'hA0);
    end

    // Stall holding A1
    step();
    chk("pre_stall_out", out_rr, 32'hA1);
    i_ready = 1'b0;
    #1;
    chk("stall_ready", {28'd0, rdy_rr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out",   out_rr, 32'hA1);
      chk("stall_grant", {28'd0, gr_rr}, 32'b0010);
      chk("stall_valid", {31'd0, ov_rr}, 32'd1);
    end
    i_ready = 1'b1;
    step();
    chk("post_stall_out", out_rr, 32'hA2);

    // Sparse and wrap (pointer at 3)
    i_valid = 4'b0010;
    #1;
    chk("sparse_ready", {28'd0, rdy_rr}, 32'b0010);
    step();
    chk("sparse_out", out_rr, 32'hA1);
    i_valid = 4'b0011;
    #1;
    chk("wrap_ready", {28'd0, rdy_rr}, 32'b0001);
    step();
    chk("wrap_out",   out_rr, 32'hA0);
    chk("wrap_grant", {28'd0, gr_rr}, 32'b0001);

    // Fixed priority: channel 2 always beats channel 3
    i_valid = 4'b1100;
    #1;
    chk("fx_ready", {28'd0, rdy_fx}, 32'b0100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fx_out",   out_fx, 32'hA2);
      chk("fx_grant", {28'd0, gr_fx}, 32'b0100);
    end
    i_valid = 4'b0000;
    step();
    chk("fx_idle_valid", {31'd0, ov_fx}, 32'd0);
    chk("rr_idle_valid", {31'd0, ov_rr}, 32'd0);

    // Mid-operation reset with pointer at 2
    i_valid = 4'b0010;
    step();
    chk("mid_out", out_rr, 32'hA1);
    rst     = 1'b1;
    i_valid = 4'b1111;
    step();
    chk("mid_rst_valid", {31'd0, ov_rr}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_first_ready", {28'd0, rdy_rr}, 32'b0001);
    step();
    chk("mid_first_out", out_rr, 32'hA0);

    // Mixed request/backpressure patterns, checked by the model
    for (int i = 0; i < 16; i++) begin
      i_ready = pat[i][5];
      i_valid = pat[i][4:1];
      step();
    end
    i_valid = 4'b0000;
    i_ready = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arb_mux_one_hot.md
Name: rr_arb_mux_one_hot

Overview:
Parametrised N-channel arbitrated multiplexer with a one-hot internal grant and a registered, valid/ready-handshaked output stage.
- Used where several requesters share one downstream consumer, e.g. instruction-fetch and data ports sharing the memory interface, or multiple writeback sources.
- Generalises the fixed 4-input one-hot mux: channel count and width are parameters, the one-hot select is generated internally by an arbiter, and the output is buffered.

Parameters:
- LENGTH, 32, data width per channel in bits (>=1).
- CH, 4, number of input channels (>=2).
- RR_MODE, 1, arbitration policy: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  CH*LENGTH  flattened channel data; channel k occupies bits [k*LENGTH +: LENGTH].
- i_valid  input  CH  per-channel request/valid.
- o_ready  output  CH  per-channel accept; combinational.
- out  output  LENGTH  registered selected data.
- o_valid  output  1  out holds a valid beat.
- i_ready  input  1  downstream accept.
- o_grant  output  CH  registered one-hot tag of the source channel for the beat in out.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); only rst clears state.
- Reset values:
  - out = 0, o_valid = 0, o_grant = 0.
  - Round-robin pointer = channel 0 (channel 0 has highest priority first).
- Load condition: load_en = !o_valid || i_ready. The single output register accepts a new beat every cycle at full throughput.
- Grant (combinational, always zero or one-hot):
  - RR_MODE=1: first asserted i_valid bit searching upward from the pointer, wrapping CH-1 -> 0.
  - RR_MODE=0: lowest-index asserted i_valid bit.
- o_ready[k] = grant[k] && load_en. At most one bit is ever set. o_ready depends combinationally on i_valid and i_ready.
- A transfer on channel k occurs when i_valid[k] && o_ready[k]. On the next edge:
  - out <= channel k data.
  - o_grant <= grant.
  - o_valid <= 1.
- Latency: 1 cycle from input transfer to o_valid.
- Pointer update (RR_MODE=1 only):
  - On a transfer from channel k, the pointer becomes (k+1) mod CH, wrapping from CH-1 to 0.
  - With no transfer, the pointer holds.
  - In RR_MODE=0 the pointer is unused and holds at 0.
- No request while load_en is true: o_valid <= 0. out and o_grant hold their previous values; downstream must ignore them.
- Stall (o_valid && !i_ready): out, o_grant and o_valid are held stable, o_ready = 0, and the pointer holds.
- Simultaneous pop and push (o_valid && i_ready with a pending request): the new beat replaces the old one in the same edge, with no bubble.
- Input protocol: a channel holding i_valid high must keep its data stable until its accept. Dropping i_valid before the accept is legal; the request is simply withdrawn, with no error.
- rst mid-transfer: the buffered beat is discarded (o_valid=0) and the pointer returns to 0 on that edge. o_ready is 0 only while grant is empty; with rst high and i_valid set, o_ready may assert combinationally, and upstream must qualify with rst.
- Fairness (RR_MODE=1): with all CH channels continuously valid and i_ready=1, grants cycle 0,1,...,CH-1,0. No channel waits more than CH-1 transfers.

Decomposition:
- Shared package/include holds the mode constants ARB_FIXED=0 and ARB_RR=1. No typedefs are needed because the ports are flattened vectors.
- One natural sub-module, rr_arbiter_one_hot (params CH, RR_MODE):
  - Inputs: clk, rst, request vector, advance strobe.
  - Output: one-hot grant.
  - Owns the pointer.
- The top level holds the one-hot AND-OR data select (generate loop over CH) and the output register.

Test Plan:
- Reset: assert rst 2 cycles with i_valid=4'b1111 -> out=0, o_valid=0, o_grant=0. After release with i_ready=1, the first grant is 4'b0001.
- Round-robin rotation: CH=4, all valid, data k = 32'hA0+k, i_ready=1 -> out sequence A0,A1,A2,A3,A0 with o_grant 0001,0010,0100,1000,0001. o_valid stays 1 throughout.
- Stall: o_valid=1 with out=A1, i_ready=0 for 3 cycles -> out=A1 and o_grant=0010 stay stable, o_ready=0000. Then i_ready=1 -> next beat is A2.
- Sparse and wrap: pointer=3, i_valid=4'b0010 -> grant 0010. Then pointer=2, i_valid=4'b0011 -> grant 0001, wrapping past 2 and 3 to channel 0.
- Fixed priority: RR_MODE=0, i_valid=4'b1100 continuous, i_ready=1 -> channel 2 wins every cycle and channel 3 never wins. Then i_valid=0 -> o_valid drops after 1 cycle.
- Mid-operation reset: o_valid=1, pointer=2, then rst pulse -> next edge gives o_valid=0. With all valid after release, the first grant is 0001.
